menu_key_ctrl: RTL and testbench
================================

# menu_key_ctrl

Keyboard-driven menu controller for the VGA text editor. It sits between the PS/2 scan-code receiver and the menu graphics overlay. It turns set-2 scan codes into the `item_selector` / `window_selector` pair that the overlay draws, and it issues one-cycle command strobes plus persistent editor settings (caps, colour, size) to the text datapath.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100_000_000: idle clocks before the confirm dialog auto-cancels (2 s at 50 MHz). Used only with `MENU_KEY_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system pixel/logic clock.
- `reset`  in  1  asynchronous, active-high reset.
- `scan_code`  in  8  PS/2 set-2 byte from the receiver.
- `scan_done_tick`  in  1  one-cycle strobe; `scan_code` valid this cycle.
- `item_selector`  out  3  to overlay. TEXT state: highlighted top item 1..6. DIALOG state: `{2'b00, dlg_choice}`.
- `window_selector`  out  1  1 = top text menu shown, 0 = confirm dialog shown.
- `cmd_open`, `cmd_save`, `cmd_exit`  out  1 each  one-cycle strobe on confirmed command.
- `caps_on`  out  1  caps-lock setting.
- `text_color`  out  3  RGB text colour.
- `text_size`  out  2  font scale index.

All outputs are registered.

## Operation
- Decoder, keys accepted on `scan_done_tick`:
  - `F0` sets `brk`; the next byte is discarded and clears `brk`.
  - `E0` sets `ext`. The next non-`F0` byte is decoded as extended, then `ext` clears. In `E0 F0 xx`, `ext` stays set through `F0` and `xx` is discarded.
  - Recognised make codes: LEFT = `E0 6B`, RIGHT = `E0 74`, ENTER = `5A`, ESC = `76`. All other codes are ignored and cause no state change.
- FSM states: TEXT, DIALOG.
- TEXT (`window_selector`=1):
  - `top_item` is 1..6. LEFT decrements and RIGHT increments, wrapping 1↔6.
  - ENTER on 1/2/3: latch `pending` = item, set `dlg_choice`=0, go to DIALOG.
  - ENTER on 4: toggle `caps_on`.
  - ENTER on 5: `text_color` cycles 3'b000→001→…→110→000. Value 111 is skipped because it is the background.
  - ENTER on 6: `text_size` increments modulo 3 (0,1,2,0).
  - ESC: no effect.
- DIALOG (`window_selector`=0):
  - LEFT/RIGHT toggle `dlg_choice` (0 = accept, 1 = cancel).
  - ENTER with choice 0: pulse the `cmd_*` matching `pending`, return to TEXT.
  - ENTER with choice 1, or ESC: return to TEXT without a strobe.
  - `top_item` is preserved across the dialog.
- On return to TEXT, `item_selector` shows `top_item` again.

## Timing
- Reset values:
  - `window_selector`=1, `item_selector`=3'd1, `top_item`=1, `dlg_choice`=0.
  - `cmd_*`=0, `caps_on`=0, `text_color`=3'b000, `text_size`=2'd0.
  - `brk`=0, `ext`=0, timeout counter=0.
- Latency: a code on `scan_done_tick` at edge N produces all output changes at edge N+1, with one clock of latency.
- `cmd_*` is high for exactly one clock, at edge N+1 after the accepting ENTER. At most one strobe is high in any cycle.
- Settings change once per ENTER make code. Typematic repeats (repeated make codes) each count as a new key.
- Reset mid-dialog: the block returns immediately to reset values and no strobe is emitted.
- `scan_done_tick` held high on consecutive cycles: each cycle is processed as a separate byte.

## Configuration
- `MENU_KEY_TIMEOUT_EN`, when defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` runs only in DIALOG.
  - It clears on entry to DIALOG and on every `scan_done_tick`.
  - When it reaches `TIMEOUT_CYCLES-1` with no tick that cycle, the FSM returns to TEXT with no strobe, behaving like ESC.
  - If a tick coincides with the terminal count, the key is processed and the timeout does not fire.
- Not defined: no counter is compiled in, and DIALOG waits indefinitely.

## Test plan
- Reset, then bytes `E0 74` ×6 → `item_selector` steps 2,3,4,5,6,1, and `window_selector` stays 1.
- From item 2: ENTER (`5A`) → `window_selector`=0, `item_selector`=0. Then ENTER → `cmd_save` high for exactly 1 clock, `window_selector`=1, `item_selector`=2.
- From item 3 DIALOG: `E0 74` (choice 1) then `5A` → `item_selector` 1 then back to 3, no `cmd_exit`. Repeat using `76` (ESC) → same result.
- Item 5, ENTER ×8 → `text_color` 1,2,3,4,5,6,0,1. Item 6, ENTER ×4 → `text_size` 1,2,0,1.
- Break handling: `F0 5A` on item 4 → `caps_on` unchanged. `E0 F0 6B` → `item_selector` unchanged.
- With `MENU_KEY_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: enter DIALOG and idle 16 clocks → `window_selector`=1 with no strobe. A key at clock 15 restarts the count. Assert reset mid-dialog → all outputs at reset values.

Source files
------------

// File: rtl/menu_key_ctrl.sv
// Menu controller: turns PS/2 set-2 scan codes into overlay selectors, command strobes and editor settings.
// Optional dialog auto-cancel is compiled in when MENU_KEY_TIMEOUT_EN is defined.
module menu_key_ctrl #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_done_tick,
  output logic [2:0] item_selector,
  output logic       window_selector,
  output logic       cmd_open,
  output logic       cmd_save,
  output logic       cmd_exit,
  output logic       caps_on,
  output logic [2:0] text_color,
  output logic [1:0] text_size
);

  typedef enum logic {S_TEXT, S_DIALOG} state_t;

  state_t     state_q, state_d;
  logic [2:0] top_q, top_d;
  logic       choice_q, choice_d;
  logic [1:0] pending_q, pending_d;
  logic       caps_q, caps_d;
  logic [2:0] color_q, color_d;
  logic [1:0] size_q, size_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [2:0] item_q, item_d;
  logic       win_q, win_d;
  logic       open_q, open_d;
  logic       save_q, save_d;
  logic       exit_q, exit_d;

  logic key_left, key_right, key_enter, key_esc;
  logic timeout_fire;

  // Byte-level decoder: a byte after F0 is always discarded, E0 qualifies the next real byte.
  always_comb begin
    brk_d     = brk_q;
    ext_d     = ext_q;
    key_left  = 1'b0;
    key_right = 1'b0;
    key_enter = 1'b0;
    key_esc   = 1'b0;
    if (scan_done_tick) begin
      if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (scan_code == 8'hF0) begin
        brk_d = 1'b1;
      end else if (scan_code == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        ext_d     = 1'b0;
        key_left  =  ext_q && (scan_code == 8'h6B);
        key_right =  ext_q && (scan_code == 8'h74);
        key_enter = !ext_q && (scan_code == 8'h5A);
        key_esc   = !ext_q && (scan_code == 8'h76);
      end
    end
  end

`ifdef MENU_KEY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside the dialog, so entering the dialog always starts a fresh count.
  always_comb begin
    cnt_d        = (state_q != S_DIALOG || scan_done_tick) ? '0 : cnt_q + 1'b1;
    timeout_fire = (state_q == S_DIALOG) && !scan_done_tick && (cnt_q == CNT_TERM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    choice_d  = choice_q;
    pending_d = pending_q;
    caps_d    = caps_q;
    color_d   = color_q;
    size_d    = size_q;
    open_d    = 1'b0;
    save_d    = 1'b0;
    exit_d    = 1'b0;
    case (state_q)
      S_TEXT: begin
        if (key_left) begin
          top_d = (top_q == 3'd1) ? 3'd6 : top_q - 3'd1;
        end else if (key_right) begin
          top_d = (top_q == 3'd6) ? 3'd1 : top_q + 3'd1;
        end else if (key_enter) begin
          case (top_q)
            3'd1, 3'd2, 3'd3: begin
              pending_d = top_q[1:0];
              choice_d  = 1'b0;
              state_d   = S_DIALOG;
            end
            3'd4:    caps_d  = !caps_q;
            3'd5:    color_d = (color_q == 3'd6) ? 3'd0 : color_q + 3'd1;
            3'd6:    size_d  = (size_q == 2'd2) ? 2'd0 : size_q + 2'd1;
            default: ;
          endcase
        end
      end
      S_DIALOG: begin
        if (key_left || key_right) begin
          choice_d = !choice_q;
        end else if (key_enter) begin
          state_d = S_TEXT;
          if (!choice_q) begin
            open_d = (pending_q == 2'd1);
            save_d = (pending_q == 2'd2);
            exit_d = (pending_q == 2'd3);
          end
        end else if (key_esc || timeout_fire) begin
          state_d = S_TEXT;
        end
      end
      default: state_d = S_TEXT;
    endcase
    win_d  = (state_d == S_TEXT);
    item_d = win_d ? top_d : {2'b00, choice_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_TEXT;
      top_q     <= 3'd1;
      choice_q  <= 1'b0;
      pending_q <= 2'd0;
      caps_q    <= 1'b0;
      color_q   <= 3'd0;
      size_q    <= 2'd0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      item_q    <= 3'd1;
      win_q     <= 1'b1;
      open_q    <= 1'b0;
      save_q    <= 1'b0;
      exit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      top_q     <= top_d;
      choice_q  <= choice_d;
      pending_q <= pending_d;
      caps_q    <= caps_d;
      color_q   <= color_d;
      size_q    <= size_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      item_q    <= item_d;
      win_q     <= win_d;
      open_q    <= open_d;
      save_q    <= save_d;
      exit_q    <= exit_d;
    end
  end

  assign item_selector   = item_q;
  assign window_selector = win_q;
  assign cmd_open        = open_q;
  assign cmd_save        = save_q;
  assign cmd_exit        = exit_q;
  assign caps_on         = caps_q;
  assign text_color      = color_q;
  assign text_size       = size_q;

endmodule

// File: tb/tb_menu_key_ctrl.sv
// Self-checking bench for menu_key_ctrl: menu-level reference model compared every cycle plus directed literal checks.
module tb_menu_key_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_done_tick = 1'b0;
  logic [2:0] item_selector;
  logic       window_selector;
  logic       cmd_open, cmd_save, cmd_exit, caps_on;
  logic [2:0] text_color;
  logic [1:0] text_size;

  always #5 clk = ~clk;

  menu_key_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_done_tick(scan_done_tick),
    .item_selector(item_selector), .window_selector(window_selector),
    .cmd_open(cmd_open), .cmd_save(cmd_save), .cmd_exit(cmd_exit),
    .caps_on(caps_on), .text_color(text_color), .text_size(text_size)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model in menu terms: which screen, which item, which dialog answer.
  bit m_in_dialog, m_caps, m_brk, m_ext, m_open, m_save, m_exit, m_was_dlg;
  int m_top, m_choice, m_pending, m_color, m_size, m_idle;

  task m_reset();
    m_in_dialog = 0; m_top = 1; m_choice = 0; m_pending = 0;
    m_caps = 0; m_color = 0; m_size = 0; m_brk = 0; m_ext = 0;
    m_open = 0; m_save = 0; m_exit = 0; m_idle = 0;
  endtask

  task m_apply(input logic [7:0] b);
    bit e;
    if (m_brk) begin m_brk = 0; m_ext = 0; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    e = m_ext;
    m_ext = 0;
    if (!m_in_dialog) begin
      if (e && b == 8'h6B) m_top = ((m_top - 1 + 5) % 6) + 1;
      else if (e && b == 8'h74) m_top = (m_top % 6) + 1;
      else if (!e && b == 8'h5A) begin
        if (m_top <= 3) begin m_pending = m_top; m_choice = 0; m_in_dialog = 1; end
        else if (m_top == 4) m_caps = !m_caps;
        else if (m_top == 5) m_color = (m_color + 1) % 7;
        else m_size = (m_size + 1) % 3;
      end
    end else begin
      if (e && (b == 8'h6B || b == 8'h74)) m_choice = 1 - m_choice;
      else if (!e && b == 8'h5A) begin
        if (m_choice == 0) begin
          m_open = (m_pending == 1); m_save = (m_pending == 2); m_exit = (m_pending == 3);
        end
        m_in_dialog = 0;
      end else if (!e && b == 8'h76) m_in_dialog = 0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else begin
      m_was_dlg = m_in_dialog;
      m_open = 0; m_save = 0; m_exit = 0;
      if (scan_done_tick) m_apply(scan_code);
`ifdef MENU_KEY_TIMEOUT_EN
      else if (m_was_dlg && m_idle == 15) m_in_dialog = 0;
      if (m_was_dlg && !scan_done_tick) m_idle++;
      else m_idle = 0;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.item", 32'(item_selector), m_in_dialog ? m_choice : m_top);
      chk("m.window", 32'(window_selector), m_in_dialog ? 0 : 1);
      chk("m.open", 32'(cmd_open), 32'(m_open));
      chk("m.save", 32'(cmd_save), 32'(m_save));
      chk("m.exit", 32'(cmd_exit), 32'(m_exit));
      chk("m.caps", 32'(caps_on), 32'(m_caps));
      chk("m.color", 32'(text_color), m_color);
      chk("m.size", 32'(text_size), m_size);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code = b;
    scan_done_tick = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
  endtask

  task automatic key_right(); send(8'hE0); send(8'h74); endtask
  task automatic key_left();  send(8'hE0); send(8'h6B); endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int exp_item[6]  = '{2, 3, 4, 5, 6, 1};
  int exp_color[8] = '{1, 2, 3, 4, 5, 6, 0, 1};
  int exp_size[4]  = '{1, 2, 0, 1};

  initial begin
    idle(2);
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst.item", 32'(item_selector), 1);
    chk("rst.window", 32'(window_selector), 1);
    chk("rst.caps", 32'(caps_on), 0);
    chk("rst.color", 32'(text_color), 0);
    chk("rst.size", 32'(text_size), 0);

    for (int i = 0; i < 6; i++) begin
      key_right();
      chk("walk.item", 32'(item_selector), exp_item[i]);
      chk("walk.window", 32'(window_selector), 1);
    end

    // Save: item 2, accept
    key_right();
    send(8'h5A);
    chk("save.dlg_win", 32'(window_selector), 0);
    chk("save.dlg_item", 32'(item_selector), 0);
    send(8'h5A);
    chk("save.strobe", 32'(cmd_save), 1);
    chk("save.win", 32'(window_selector), 1);
    chk("save.item", 32'(item_selector), 2);
    idle(1);
    chk("save.strobe_off", 32'(cmd_save), 0);

    // Exit: cancel by choice, then by ESC
    key_right();
    send(8'h5A);
    key_right();
    chk("exit.choice", 32'(item_selector), 1);
    send(8'h5A);
    chk("exit.cancel_item", 32'(item_selector), 3);
    chk("exit.no_strobe", 32'(cmd_exit), 0);
    send(8'h5A);
    send(8'h76);
    chk("exit.esc_item", 32'(item_selector), 3);
    chk("exit.esc_win", 32'(window_selector), 1);
    chk("exit.esc_no_strobe", 32'(cmd_exit), 0);

    key_right(); key_right();
    for (int i = 0; i < 8; i++) begin
      send(8'h5A);
      chk("color", 32'(text_color), exp_color[i]);
    end
    key_right();
    for (int i = 0; i < 4; i++) begin
      send(8'h5A);
      chk("size", 32'(text_size), exp_size[i]);
    end

    // Break handling on item 4
    key_left(); key_left();
    send(8'hF0); send(8'h5A);
    chk("brk.caps", 32'(caps_on), 0);
    send(8'h5A);
    chk("caps.on", 32'(caps_on), 1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("brk.ext_item", 32'(item_selector), 4);
    key_left();
    chk("after_brk.item", 32'(item_selector), 3);

    // Back-to-back ticks: E0 74 on consecutive cycles
    @(negedge clk);
    scan_code = 8'hE0; scan_done_tick = 1'b1;
    @(negedge clk);
    scan_code = 8'h74;
    @(negedge clk);
    scan_done_tick = 1'b0;
    chk("b2b.item", 32'(item_selector), 4);

    // Open: go to item 1 and accept
    key_left(); key_left(); key_left();
    send(8'h5A);
    send(8'h5A);
    chk("open.strobe", 32'(cmd_open), 1);
    chk("open.item", 32'(item_selector), 1);

    // Dialog idling; a key late in the count restarts it
    send(8'h5A);
    idle(12);
    key_right();
    idle(8);
    chk("idle.still_dlg", 32'(window_selector), 0);
    idle(20);
`ifdef MENU_KEY_TIMEOUT_EN
    chk("idle.timeout", 32'(window_selector), 1);
`else
    chk("idle.no_timeout", 32'(window_selector), 0);
`endif

    // Reset while the dialog is open on item 2
    if (window_selector) begin key_right(); send(8'h5A); end
    else begin send(8'h76); key_right(); send(8'h5A); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst2.window", 32'(window_selector), 1);
    chk("rst2.item", 32'(item_selector), 1);
    chk("rst2.strobes", 32'({cmd_open, cmd_save, cmd_exit}), 0);
    chk("rst2.caps", 32'(caps_on), 0);
    chk("rst2.color", 32'(text_color), 0);
    chk("rst2.size", 32'(text_size), 0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h5A);
    chk("rst2.fresh_dlg", 32'(window_selector), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
